// File: rtl/bvb_arbiter.sv
// Per-bank round-robin arbiter between channel column-id FIFOs and vector buffer banks.
// Optional BVB_ARB_STATS_EN adds per-bank saturating conflict counters on conflict_count.

module bvb_arb_bank #(
  parameter int N   = 4,
  parameter int IDW = 16,
  parameter int BB  = 2,
  parameter int AW  = IDW - BB
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        tgt_i,
  input  logic [N-1:0][IDW-1:0] id_i,
  output logic [N-1:0]        gnt_o,
  output logic                valid_o,
  output logic [AW-1:0]       addr_o,
  output logic [BB-1:0]       src_o
`ifdef BVB_ARB_STATS_EN
  , output logic [31:0]       conflict_o
`endif
);
  logic [BB-1:0] ptr_q, ptr_d, win, idx;
  logic          hit;
  logic          valid_q;
  logic [AW-1:0] addr_q;
  logic [BB-1:0] src_q;

  // Scan from ptr upward; N is a power of two so BB-bit addition wraps modulo N.
  always_comb begin
    hit = 1'b0;
    win = ptr_q;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + BB'(k);
      if (!hit && tgt_i[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
    gnt_o = '0;
    if (hit) gnt_o[win] = 1'b1;
    ptr_d = hit ? win + BB'(1) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      src_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= hit;
      if (hit) begin
        addr_q <= id_i[win][IDW-1:BB];
        src_q  <= win;
      end
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign src_o   = src_q;

`ifdef BVB_ARB_STATS_EN
  logic [31:0] cnt_q;
  // More than one requester: clearing the lowest set bit leaves something.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (((tgt_i & (tgt_i - N'(1))) != '0) && (cnt_q != '1)) cnt_q <= cnt_q + 32'd1;
  end
  assign conflict_o = cnt_q;
`endif
endmodule

module bvb_arbiter #(
  parameter int channel_num    = 4,
  parameter int col_id_size    = 16,
  parameter int vec_fifo_depth = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [col_id_size*channel_num-1:0]            id,
  input  logic [channel_num-1:0]                        id_fifo_empty,
  output logic [channel_num-1:0]                        id_fifo_read,
  input  logic [channel_num-1:0]                        vec_fifo_read,
  output logic [channel_num-1:0]                        bank_valid,
  output logic [(col_id_size-$clog2(channel_num))*channel_num-1:0] bank_addr,
  output logic [$clog2(channel_num)*channel_num-1:0]    bank_src
`ifdef BVB_ARB_STATS_EN
  , output logic [32*channel_num-1:0]                   conflict_count
`endif
);
  localparam int bank_bits = $clog2(channel_num);
  localparam int AW        = col_id_size - bank_bits;
  localparam int CW        = $clog2(vec_fifo_depth + 1);

  logic [channel_num-1:0][col_id_size-1:0] id_a;
  logic [channel_num-1:0][AW-1:0]          addr_a;
  logic [channel_num-1:0][bank_bits-1:0]   src_a;
  logic [channel_num-1:0][channel_num-1:0] tgt, gnt;
  logic [channel_num-1:0][CW-1:0]          credit_q, credit_d;
  logic [channel_num-1:0]                  req, rd_raw;

  assign id_a      = id;
  assign bank_addr = addr_a;
  assign bank_src  = src_a;

  always_comb begin
    tgt = '0;
    for (int c = 0; c < channel_num; c++)
      req[c] = !id_fifo_empty[c] && (credit_q[c] != '0);
    for (int b = 0; b < channel_num; b++)
      for (int c = 0; c < channel_num; c++)
        tgt[b][c] = req[c] && (id_a[c][bank_bits-1:0] == bank_bits'(b));
  end

  // Each channel targets exactly one bank, so OR-ing bank grants yields at most one pop per channel.
  always_comb begin
    rd_raw = '0;
    for (int b = 0; b < channel_num; b++) rd_raw = rd_raw | gnt[b];
    id_fifo_read = rst ? '0 : rd_raw;
  end

  always_comb begin
    for (int c = 0; c < channel_num; c++) begin
      credit_d[c] = credit_q[c];
      if (id_fifo_read[c] && !vec_fifo_read[c])
        credit_d[c] = credit_q[c] - CW'(1);
      else if (!id_fifo_read[c] && vec_fifo_read[c] && credit_q[c] != CW'(vec_fifo_depth))
        credit_d[c] = credit_q[c] + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < channel_num; c++) credit_q[c] <= CW'(vec_fifo_depth);
    end else begin
      credit_q <= credit_d;
    end
  end

  for (genvar b = 0; b < channel_num; b++) begin : g_bank
    bvb_arb_bank #(.N(channel_num), .IDW(col_id_size), .BB(bank_bits), .AW(AW)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .tgt_i   (tgt[b]),
      .id_i    (id_a),
      .gnt_o   (gnt[b]),
      .valid_o (bank_valid[b]),
      .addr_o  (addr_a[b]),
      .src_o   (src_a[b])
`ifdef BVB_ARB_STATS_EN
      , .conflict_o (conflict_count[b*32 +: 32])
`endif
    );
  end
endmodule

// File: tb/tb_bvb_arbiter.sv
// Directed self-checking bench for bvb_arbiter (channel_num=4, col_id_size=16, vec_fifo_depth=8).
module tb_bvb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] id;
  logic [3:0]  id_fifo_empty, id_fifo_read, vec_fifo_read, bank_valid;
  logic [55:0] bank_addr;
  logic [7:0]  bank_src;
`ifdef BVB_ARB_STATS_EN
  logic [127:0] conflict_count;
`endif
  int tests = 0, fails = 0;

  bvb_arbiter #(.channel_num(4), .col_id_size(16), .vec_fifo_depth(8)) dut (
    .clk(clk), .rst(rst), .id(id), .id_fifo_empty(id_fifo_empty),
    .id_fifo_read(id_fifo_read), .vec_fifo_read(vec_fifo_read),
    .bank_valid(bank_valid), .bank_addr(bank_addr), .bank_src(bank_src)
`ifdef BVB_ARB_STATS_EN
    , .conflict_count(conflict_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; id_fifo_empty = 4'hF; vec_fifo_read = 4'h0; id = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Count pops of channel ch over n cycles, sampling at negedge.
  task automatic count_grants(input int ch, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (id_fifo_read[ch]) cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bank_valid !== 4'h0) begin fails++; $display("FAIL reset_valid got %h exp 0", bank_valid); end
    tests++; if (bank_addr !== 56'h0) begin fails++; $display("FAIL reset_addr got %h exp 0", bank_addr); end
    tests++; if (bank_src !== 8'h0) begin fails++; $display("FAIL reset_src got %h exp 0", bank_src); end
    rst = 1'b1; id_fifo_empty = 4'h0; #1;
    tests++; if (id_fifo_read !== 4'h0) begin fails++; $display("FAIL reset_mask got %b exp 0000", id_fifo_read); end
    tick(); rst = 1'b0; id_fifo_empty = 4'hF;
  endtask

  task automatic test_distinct();
    do_reset();
    id = {16'd3, 16'd2, 16'd1, 16'd0}; id_fifo_empty = 4'h0; #1;
    tests++; if (id_fifo_read !== 4'b1111) begin fails++; $display("FAIL distinct_read got %b exp 1111", id_fifo_read); end
    tick(); id_fifo_empty = 4'hF;
    tests++; if (bank_valid !== 4'b1111) begin fails++; $display("FAIL distinct_valid got %b exp 1111", bank_valid); end
    tests++; if (bank_addr !== 56'h0) begin fails++; $display("FAIL distinct_addr got %h exp 0", bank_addr); end
    tests++; if (bank_src !== 8'b11100100) begin fails++; $display("FAIL distinct_src got %b exp 11100100", bank_src); end
  endtask

  // Conflict, then idle (pointer hold), then reset mid-stream with credit-restore check.
  task automatic test_conflict_empty_reset();
    int cnt;
    logic [3:0] exp;
    do_reset();
    id = {16'd8, 16'd8, 16'd8, 16'd8}; id_fifo_empty = 4'h0;
    for (int i = 0; i < 5; i++) begin
      #1; exp = 4'b0001 << (i % 4);
      tests++; if (id_fifo_read !== exp) begin fails++; $display("FAIL conflict_read[%0d] got %b exp %b", i, id_fifo_read, exp); end
      tick();
      tests++; if (bank_valid !== 4'b0001 || bank_addr[13:0] !== 14'd2 || bank_src[1:0] !== 2'(i % 4)) begin
        fails++; $display("FAIL conflict_cmd[%0d] got v=%b a=%0d s=%0d exp v=0001 a=2 s=%0d", i, bank_valid, bank_addr[13:0], bank_src[1:0], i % 4);
      end
    end
`ifdef BVB_ARB_STATS_EN
    tests++; if (conflict_count[31:0] !== 32'd5) begin fails++; $display("FAIL conflict_count got %0d exp 5", conflict_count[31:0]); end
`endif
    id_fifo_empty = 4'hF; #1;
    tests++; if (id_fifo_read !== 4'h0) begin fails++; $display("FAIL empty_read got %b exp 0000", id_fifo_read); end
    tick(); tick();
    tests++; if (bank_valid !== 4'h0) begin fails++; $display("FAIL empty_valid got %b exp 0000", bank_valid); end
    id_fifo_empty = 4'h0; #1;
    tests++; if (id_fifo_read !== 4'b0010) begin fails++; $display("FAIL empty_ptr_hold got %b exp 0010", id_fifo_read); end
    tick(); #1;
    tests++; if (id_fifo_read !== 4'b0100) begin fails++; $display("FAIL mid_pre got %b exp 0100", id_fifo_read); end
    rst = 1'b1; #1;
    tests++; if (id_fifo_read !== 4'h0) begin fails++; $display("FAIL mid_mask got %b exp 0000", id_fifo_read); end
    tick();
    tests++; if (bank_valid !== 4'h0) begin fails++; $display("FAIL mid_valid got %b exp 0000", bank_valid); end
    rst = 1'b0; #1;
    tests++; if (id_fifo_read !== 4'b0001) begin fails++; $display("FAIL mid_first got %b exp 0001", id_fifo_read); end
    id_fifo_empty = 4'hF; tick();
    id[31:16] = 16'h0015; id_fifo_empty = 4'b1101;
    count_grants(1, 12, cnt);
    tests++; if (cnt !== 8) begin fails++; $display("FAIL mid_credit_restore got %0d exp 8", cnt); end
    id_fifo_empty = 4'hF;
  endtask

  task automatic test_credit();
    int cnt;
    do_reset();
    id[31:16] = 16'h0015; id_fifo_empty = 4'b1101; #1;
    tests++; if (id_fifo_read !== 4'b0010) begin fails++; $display("FAIL credit_first got %b exp 0010", id_fifo_read); end
    tick();
    tests++; if (bank_valid !== 4'b0010 || bank_addr[27:14] !== 14'd5 || bank_src[3:2] !== 2'd1) begin
      fails++; $display("FAIL credit_cmd got v=%b a=%0d s=%0d exp v=0010 a=5 s=1", bank_valid, bank_addr[27:14], bank_src[3:2]);
    end
    count_grants(1, 10, cnt);
    tests++; if (cnt !== 7) begin fails++; $display("FAIL credit_drain got %0d exp 7", cnt); end
    #1;
    tests++; if (id_fifo_read !== 4'h0) begin fails++; $display("FAIL credit_zero got %b exp 0000", id_fifo_read); end
    vec_fifo_read = 4'b0010; tick(); vec_fifo_read = 4'h0;
    count_grants(1, 5, cnt);
    tests++; if (cnt !== 1) begin fails++; $display("FAIL credit_return got %0d exp 1", cnt); end
    id_fifo_empty = 4'hF;
  endtask

  task automatic test_back_to_back();
    int cnt;
    do_reset();
    id[47:32] = 16'd2; id_fifo_empty = 4'b1011; vec_fifo_read = 4'b0100;
    count_grants(2, 20, cnt);
    tests++; if (cnt !== 20) begin fails++; $display("FAIL b2b_grants got %0d exp 20", cnt); end
    vec_fifo_read = 4'h0;
    count_grants(2, 12, cnt);
    tests++; if (cnt !== 8) begin fails++; $display("FAIL b2b_credit got %0d exp 8", cnt); end
    id_fifo_empty = 4'hF;
  endtask

  task automatic test_saturate();
    int cnt;
    do_reset();
    vec_fifo_read = 4'b1000; tick(); vec_fifo_read = 4'h0;
    id[63:48] = 16'd3; id_fifo_empty = 4'b0111;
    count_grants(3, 12, cnt);
    tests++; if (cnt !== 8) begin fails++; $display("FAIL credit_saturate got %0d exp 8", cnt); end
    id_fifo_empty = 4'hF;
  endtask

  initial begin
    rst = 1'b1; id = '0; id_fifo_empty = 4'hF; vec_fifo_read = 4'h0;
    test_reset();
    test_distinct();
    test_conflict_empty_reset();
    test_credit();
    test_back_to_back();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bvb_arbiter.md
# bvb_arbiter

Per-bank round-robin scheduler between the channel column-id FIFOs and the banks of the banked vector buffer. Each cycle it picks, for every bank, at most one channel whose head column id maps to that bank. It pops the winning FIFO heads and issues registered bank read commands tagged with the requesting channel. Per-channel credit counters ensure a grant is only issued when the channel's vector return FIFO has guaranteed space.

## Interface
- channel_num, 4, number of channels; equals number of banks; power of two, >= 2
- col_id_size, 16, column id width
- vec_fifo_depth, 8, depth of each per-channel vector return FIFO (initial credit)
- bank_bits (localparam), log2(channel_num)

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- id  in  col_id_size*channel_num  head column id of each channel FIFO; slice c = id[c*col_id_size+:col_id_size]
- id_fifo_empty  in  channel_num  per-channel FIFO empty
- id_fifo_read  out  channel_num  pop strobe; combinational from current inputs and state
- vec_fifo_read  in  channel_num  consumer pop of channel c's vector return FIFO (credit return)
- bank_valid  out  channel_num  registered read command valid, one bit per bank
- bank_addr  out  (col_id_size-bank_bits)*channel_num  registered in-bank address, id >> bank_bits
- bank_src  out  bank_bits*channel_num  registered index of the granted channel
- conflict_count  out  32*channel_num  present only with BVB_ARB_STATS_EN

## Operation
- Bank of channel c's head is id_c[bank_bits-1:0].
- Request: req[c] = !id_fifo_empty[c] && credit[c] != 0.
- Each bank b has a round-robin pointer ptr[b]. Among requesting channels targeting b, the winner is the first channel at or after ptr[b], in ascending modulo channel_num order.
- Grant effects:
  - id_fifo_read[winner] = 1.
  - Next cycle: bank_valid[b] = 1, bank_addr[b] = id_winner >> bank_bits, bank_src[b] = winner.
  - ptr[b] <= (winner+1) mod channel_num.
- Bank with no request: bank_valid[b] <= 0, ptr[b] unchanged, bank_addr/bank_src hold their previous values.
- A channel presents one head, so it receives at most one grant per cycle. This preserves per-channel request order into the return FIFO.
- Credit counters, width clog2(vec_fifo_depth+1), one per channel:
  - Grant only: decrement.
  - vec_fifo_read[c] only: increment.
  - Both in the same cycle: unchanged.
  - vec_fifo_read[c] when credit == vec_fifo_depth is a protocol violation. The counter saturates and does not wrap.
- Credit 0 removes channel c from arbitration. Its FIFO is not popped.

## Timing
- Grant decision and id_fifo_read are in cycle t. bank_valid/addr/src are registered and visible in t+1. Latency is 1 cycle.
- Back-to-back grants to the same bank every cycle are allowed. Throughput is 1 command per bank per cycle.
- Reset values:
  - bank_valid = 0, bank_addr = 0, bank_src = 0.
  - ptr[b] = 0.
  - credit[c] = vec_fifo_depth.
  - conflict_count = 0.
- While rst is high, id_fifo_read = 0 (combinationally masked).
- Reset mid-operation: commands already registered are dropped on the next edge. Credits are restored to full.
- id_fifo_empty[c] rising in the same cycle it would win: no grant, because req is evaluated on current inputs.

## Configuration
- BVB_ARB_STATS_EN defined:
  - Per-bank 32-bit counter increments in every cycle where two or more channels request that bank.
  - Saturates at 2^32-1 and is exposed on conflict_count.
- BVB_ARB_STATS_EN undefined: the conflict_count port and counters do not exist. Grant behaviour is identical.

## Test plan
- **Distinct banks:** channel_num=4, heads id = {3,2,1,0} (channel c holds id c), all non-empty.
  - Cycle t: id_fifo_read=4'b1111.
  - Cycle t+1: bank_valid=4'b1111, bank_addr all 0, bank_src[b]=b.
- **Full conflict:** all four channels hold id 8 (bank 0, addr 2) every cycle.
  - Grants rotate over channels 0,1,2,3,0.
  - bank_valid=4'b0001 each cycle, bank_addr[0]=2.
  - With BVB_ARB_STATS_EN: conflict_count[0]=5 after 5 cycles.
- **Credit exhaustion:** vec_fifo_depth=8, channel 1 alone requests bank 1 with no vec_fifo_read.
  - Exactly 8 grants, then id_fifo_read[1]=0.
  - One vec_fifo_read[1] pulse: exactly one further grant.
- **Simultaneous grant and credit return:** channel 2 granted and vec_fifo_read[2]=1 in the same cycle for 20 cycles.
  - credit[2] stays 8.
  - Grants continue every cycle.
- **Empty handling:** all id_fifo_empty=1.
  - id_fifo_read=0, bank_valid=0.
  - ptr values unchanged, checked by the next conflict grant order starting at the prior pointer.
- **Reset mid-stream:** assert rst for 1 cycle during the full-conflict run.
  - Next cycle bank_valid=0 and credits=8.
  - After release, first grant goes to channel 0.
